// File: rtl/zap_shift_arbiter.sv
// zap_shift_arbiter
//
// Shares one ARM barrel shifter between the ALU operand path (port 0) and
// the load/store offset path (port 1). A round-robin arbiter grants one
// requester per cycle into a single registered result slot. The block
// applies the ARM boundary corrections that a raw shifter does not handle:
// amount 0, the #32 immediate encodings, RRX, and amounts of 32 or more.
//
// Ports:
//   i_clk, i_reset         clock, synchronous active-high reset
//   i_flush                synchronous flush: empties the slot, blocks grants
//   i_valid_N / o_ready_N  per-port request handshake (N = 0, 1)
//   i_source_N             32-bit operand to shift
//   i_amount_N             8-bit shift amount (already doubled for RORI)
//   i_shift_type_N         LSL=0, LSR=1, ASR=2, ROR=3, RORI=4
//   i_reg_shift_N          1 = register-specified amount, 0 = immediate
//   i_carry_in_N           current CPSR C flag
//   o_valid / i_ready      result slot handshake
//   o_result, o_carry      corrected shifter result and carry-out
//   o_grant_id             port that produced the current result
module zap_shift_arbiter #(
    parameter int SHIFT_OPS = 5
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_flush,
    input  logic                         i_valid_0,
    input  logic                         i_valid_1,
    output logic                         o_ready_0,
    output logic                         o_ready_1,
    input  logic [31:0]                  i_source_0,
    input  logic [31:0]                  i_source_1,
    input  logic [7:0]                   i_amount_0,
    input  logic [7:0]                   i_amount_1,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type_0,
    input  logic [$clog2(SHIFT_OPS)-1:0] i_shift_type_1,
    input  logic                         i_reg_shift_0,
    input  logic                         i_reg_shift_1,
    input  logic                         i_carry_in_0,
    input  logic                         i_carry_in_1,
    output logic                         o_valid,
    input  logic                         i_ready,
    output logic [31:0]                  o_result,
    output logic                         o_carry,
    output logic                         o_grant_id
);

    // Returns {carry, result} with all ARM boundary cases resolved.
    function automatic logic [32:0] correct_shift(
        input logic [31:0]                  src,
        input logic [7:0]                   amt,
        input logic [$clog2(SHIFT_OPS)-1:0] op,
        input logic                         reg_shift,
        input logic                         cin
    );
        logic [31:0] res;
        logic        cry;
        logic [31:0] rot;
        logic [7:0]  eff;
        res = src;
        cry = cin;
        // A shift of 32 yields 0, so a zero rotate distance leaves src intact.
        rot = (src >> amt[4:0]) | (src << (6'd32 - {1'b0, amt[4:0]}));
        // Immediate LSR/ASR #0 encode a shift by 32.
        eff = (!reg_shift && amt == 8'd0 && (op == 3'd1 || op == 3'd2)) ? 8'd32 : amt;
        case (op)
            3'd0: begin
                if (amt != 8'd0) begin
                    if (amt < 8'd32) begin
                        res = src << amt[4:0];
                        cry = src[5'd0 - amt[4:0]];
                    end else begin
                        res = 32'd0;
                        cry = (amt == 8'd32) ? src[0] : 1'b0;
                    end
                end
            end
            3'd1: begin
                if (eff != 8'd0) begin
                    if (eff < 8'd32) begin
                        res = src >> eff[4:0];
                        cry = src[eff[4:0] - 5'd1];
                    end else begin
                        res = 32'd0;
                        cry = (eff == 8'd32) ? src[31] : 1'b0;
                    end
                end
            end
            3'd2: begin
                if (eff != 8'd0) begin
                    if (eff < 8'd32) begin
                        res = $signed(src) >>> eff[4:0];
                        cry = src[eff[4:0] - 5'd1];
                    end else begin
                        res = {32{src[31]}};
                        cry = src[31];
                    end
                end
            end
            3'd3: begin
                if (amt == 8'd0) begin
                    // Register ROR by 0 passes through; immediate ROR #0 is RRX.
                    if (!reg_shift) begin
                        res = {cin, src[31:1]};
                        cry = src[0];
                    end
                end else begin
                    res = rot;
                    cry = rot[31];
                end
            end
            3'd4: begin
                if (amt != 8'd0) begin
                    res = rot;
                    cry = rot[31];
                end
            end
            default: begin
                res = src;
                cry = cin;
            end
        endcase
        return {cry, res};
    endfunction

    logic                         vld_p1;
    logic [31:0]                  result_p1;
    logic                         carry_p1;
    logic                         id_p1;
    logic                         ptr;
    logic                         slot_free;
    logic                         can_grant;
    logic                         contested;
    logic                         grant_0;
    logic                         grant_1;
    logic [31:0]                  sel_source;
    logic [7:0]                   sel_amount;
    logic [$clog2(SHIFT_OPS)-1:0] sel_type;
    logic                         sel_reg;
    logic                         sel_carry;
    logic [32:0]                  shifted;

    assign slot_free = !vld_p1 || i_ready;
    assign can_grant = slot_free && !i_flush && !i_reset;
    assign contested = i_valid_0 && i_valid_1;
    // ptr = 0 favours port 0 when both ports request.
    assign grant_0   = can_grant && i_valid_0 && (!i_valid_1 || !ptr);
    assign grant_1   = can_grant && i_valid_1 && (!i_valid_0 || ptr);
    assign o_ready_0 = grant_0;
    assign o_ready_1 = grant_1;

    always_comb begin
        sel_source = i_source_0;
        sel_amount = i_amount_0;
        sel_type   = i_shift_type_0;
        sel_reg    = i_reg_shift_0;
        sel_carry  = i_carry_in_0;
        if (grant_1) begin
            sel_source = i_source_1;
            sel_amount = i_amount_1;
            sel_type   = i_shift_type_1;
            sel_reg    = i_reg_shift_1;
            sel_carry  = i_carry_in_1;
        end
    end

    assign shifted = correct_shift(sel_source, sel_amount, sel_type, sel_reg, sel_carry);

    // Stage p0 -> p1: corrected result captured into the output slot
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            vld_p1    <= 1'b0;
            result_p1 <= 32'd0;
            carry_p1  <= 1'b0;
            id_p1     <= 1'b0;
            ptr       <= 1'b0;
        end else if (i_flush) begin
            vld_p1 <= 1'b0;
        end else begin
            if (grant_0 || grant_1) begin
                vld_p1    <= 1'b1;
                result_p1 <= shifted[31:0];
                carry_p1  <= shifted[32];
                id_p1     <= grant_1;
                if (contested) begin
                    ptr <= !ptr;
                end
            end else if (i_ready) begin
                vld_p1 <= 1'b0;
            end
        end
    end

    assign o_valid    = vld_p1;
    assign o_result   = result_p1;
    assign o_carry    = carry_p1;
    assign o_grant_id = id_p1;

endmodule

// File: tb/tb_zap_shift_arbiter.sv
// Testbench for zap_shift_arbiter: directed scenarios plus a randomized run
// against a bit-serial reference model of the ARM shifter and arbiter.
module tb_zap_shift_arbiter;

    typedef struct packed {
        logic [31:0] s;
        logic [7:0]  a;
        logic [2:0]  t;
        logic        rs;
        logic        c;
        logic [31:0] er;
        logic        ec;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset, flush, in_ready;
    logic        valid_0, valid_1, ready_0, ready_1;
    logic [31:0] source_0, source_1, result;
    logic [7:0]  amount_0, amount_1;
    logic [2:0]  type_0, type_1;
    logic        reg_shift_0, reg_shift_1, carry_in_0, carry_in_1;
    logic        out_valid, out_carry, grant_id;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    zap_shift_arbiter #(.SHIFT_OPS(5)) dut (
        .i_clk(clk), .i_reset(reset), .i_flush(flush),
        .i_valid_0(valid_0), .i_valid_1(valid_1),
        .o_ready_0(ready_0), .o_ready_1(ready_1),
        .i_source_0(source_0), .i_source_1(source_1),
        .i_amount_0(amount_0), .i_amount_1(amount_1),
        .i_shift_type_0(type_0), .i_shift_type_1(type_1),
        .i_reg_shift_0(reg_shift_0), .i_reg_shift_1(reg_shift_1),
        .i_carry_in_0(carry_in_0), .i_carry_in_1(carry_in_1),
        .o_valid(out_valid), .i_ready(in_ready),
        .o_result(result), .o_carry(out_carry), .o_grant_id(grant_id)
    );

    // Reference: shift one bit at a time; carry is the last bit shifted out.
    function automatic logic [32:0] ref_shift(input vec_t v);
        logic [31:0] x;
        logic        cy;
        int          n;
        x  = v.s;
        cy = v.c;
        n  = int'(v.a);
        if (v.t > 3'd4) return {v.c, v.s};
        if (v.rs && v.a == 8'd0) return {v.c, v.s};
        case (v.t)
            3'd0: for (int i = 0; i < n; i++) begin cy = x[31]; x = {x[30:0], 1'b0}; end
            3'd1: begin
                if (n == 0) n = 32;
                for (int i = 0; i < n; i++) begin cy = x[0]; x = {1'b0, x[31:1]}; end
            end
            3'd2: begin
                if (n == 0) n = 32;
                for (int i = 0; i < n; i++) begin cy = x[0]; x = {x[31], x[31:1]}; end
            end
            3'd3: begin
                if (n == 0) begin cy = x[0]; x = {v.c, x[31:1]}; end
                else for (int i = 0; i < n; i++) begin cy = x[0]; x = {x[0], x[31:1]}; end
            end
            default: for (int i = 0; i < n; i++) begin cy = x[0]; x = {x[0], x[31:1]}; end
        endcase
        return {cy, x};
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.s = $urandom;
        case ($urandom_range(0, 5))
            0: v.a = 8'd0;
            1: v.a = 8'($urandom_range(1, 31));
            2: v.a = 8'd32;
            3: v.a = 8'd33;
            4: v.a = 8'($urandom_range(0, 255));
            default: v.a = 8'($urandom_range(0, 3) * 32);
        endcase
        v.t  = 3'($urandom_range(0, 7));
        v.rs = 1'($urandom_range(0, 1));
        v.c  = 1'($urandom_range(0, 1));
        v.er = 32'd0;
        v.ec = 1'b0;
        return v;
    endfunction

    task automatic drive(input int p, input vec_t v);
        if (p == 0) begin
            source_0 = v.s; amount_0 = v.a; type_0 = v.t;
            reg_shift_0 = v.rs; carry_in_0 = v.c; valid_0 = 1'b1;
        end else begin
            source_1 = v.s; amount_1 = v.a; type_1 = v.t;
            reg_shift_1 = v.rs; carry_in_1 = v.c; valid_1 = 1'b1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; flush = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0; in_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; flush = 1'b0; in_ready = 1'b1; valid_1 = 1'b0;
        drive(0, '{32'h8000_0001, 8'd1, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0});
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %b want 0", out_valid); end
        vectors++; if (result !== 32'h0) begin miscompares++; $display("FAIL reset_result got %h want 0", result); end
        vectors++; if (out_carry !== 1'b0 || grant_id !== 1'b0) begin miscompares++; $display("FAIL reset_carry_id got %b%b want 00", out_carry, grant_id); end
        vectors++; if (ready_0 !== 1'b0 || ready_1 !== 1'b0) begin miscompares++; $display("FAIL reset_ready got %b%b want 00", ready_0, ready_1); end
        reset = 1'b0;
        #1;
        vectors++; if (ready_0 !== 1'b1) begin miscompares++; $display("FAIL single_ready got %b want 1", ready_0); end
        @(posedge clk); #1;
        valid_0 = 1'b0;
        vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL single_valid got %b want 1", out_valid); end
        vectors++; if (result !== 32'h2 || out_carry !== 1'b1 || grant_id !== 1'b0) begin
            miscompares++; $display("FAIL single_out got %h/%b/%b want 00000002/1/0", result, out_carry, grant_id); end
    endtask

    task automatic test_contention();
        int exp_id;
        do_reset();
        drive(0, '{32'h1, 8'd1, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0});
        drive(1, '{32'h1, 8'd2, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0});
        for (int k = 0; k < 4; k++) begin
            exp_id = k % 2;
            #1;
            vectors++; if (ready_0 !== (exp_id == 0) || ready_1 !== (exp_id == 1)) begin
                miscompares++; $display("FAIL contend_ready[%0d] got %b%b want id %0d", k, ready_0, ready_1, exp_id); end
            @(posedge clk); #1;
            vectors++; if (grant_id !== 1'(exp_id) || result !== ((exp_id == 1) ? 32'h4 : 32'h2) || out_valid !== 1'b1) begin
                miscompares++; $display("FAIL contend_out[%0d] got id %b res %h want id %0d", k, grant_id, result, exp_id); end
        end
        valid_0 = 1'b0; valid_1 = 1'b0;
    endtask

    task automatic test_immediate();
        vec_t tbl [8];
        tbl = '{
            '{32'h8000_0000, 8'd0, 3'd1, 1'b0, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h8000_0000, 8'd0, 3'd2, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1},
            '{32'h0000_0003, 8'd0, 3'd3, 1'b0, 1'b1, 32'h8000_0001, 1'b1},
            '{32'h0000_1234, 8'd0, 3'd0, 1'b0, 1'b1, 32'h0000_1234, 1'b1},
            '{32'hDEAD_BEEF, 8'd0, 3'd4, 1'b0, 1'b0, 32'hDEAD_BEEF, 1'b0},
            '{32'h0000_00FF, 8'd8, 3'd4, 1'b0, 1'b0, 32'hFF00_0000, 1'b1},
            '{32'hCAFE_F00D, 8'd7, 3'd5, 1'b0, 1'b1, 32'hCAFE_F00D, 1'b1},
            '{32'h0000_00F8, 8'd4, 3'd1, 1'b0, 1'b0, 32'h0000_000F, 1'b1}
        };
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(0, tbl[i]);
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || result !== tbl[i].er || out_carry !== tbl[i].ec) begin
                miscompares++; $display("FAIL imm[%0d] got %b/%h/%b want 1/%h/%b", i, out_valid, result, out_carry, tbl[i].er, tbl[i].ec); end
        end
        valid_0 = 1'b0;
    endtask

    task automatic test_reg_large();
        vec_t tbl [10];
        tbl = '{
            '{32'hFFFF_FFFF, 8'd33,  3'd0, 1'b1, 1'b1, 32'h0000_0000, 1'b0},
            '{32'h7000_0000, 8'd200, 3'd2, 1'b1, 1'b1, 32'h0000_0000, 1'b0},
            '{32'h8000_0000, 8'd64,  3'd3, 1'b1, 1'b0, 32'h8000_0000, 1'b1},
            '{32'h0000_0001, 8'd32,  3'd0, 1'b1, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h8000_0000, 8'd32,  3'd1, 1'b1, 1'b0, 32'h0000_0000, 1'b1},
            '{32'h8000_0000, 8'd0,   3'd2, 1'b1, 1'b0, 32'h8000_0000, 1'b0},
            '{32'h0000_0003, 8'd31,  3'd0, 1'b1, 1'b0, 32'h8000_0000, 1'b1},
            '{32'h0000_000F, 8'd4,   3'd3, 1'b1, 1'b0, 32'hF000_0000, 1'b1},
            '{32'h8000_0000, 8'd40,  3'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1},
            '{32'hFFFF_FFFF, 8'd33,  3'd1, 1'b1, 1'b1, 32'h0000_0000, 1'b0}
        };
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, tbl[i]);
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || grant_id !== 1'b1 || result !== tbl[i].er || out_carry !== tbl[i].ec) begin
                miscompares++; $display("FAIL reg[%0d] got %b/%b/%h/%b want 1/1/%h/%b", i, out_valid, grant_id, result, out_carry, tbl[i].er, tbl[i].ec); end
        end
        valid_1 = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        drive(0, '{32'hA5A5_0000, 8'd4, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0});
        @(posedge clk); #1;
        valid_0 = 1'b0; in_ready = 1'b0;
        drive(1, '{32'h0000_00F8, 8'd4, 3'd1, 1'b0, 1'b0, 32'h0, 1'b0});
        for (int k = 0; k < 3; k++) begin
            #1;
            vectors++; if (ready_0 !== 1'b0 || ready_1 !== 1'b0) begin
                miscompares++; $display("FAIL bp_ready[%0d] got %b%b want 00", k, ready_0, ready_1); end
            @(posedge clk); #1;
            vectors++; if (out_valid !== 1'b1 || result !== 32'h5A50_0000 || out_carry !== 1'b0 || grant_id !== 1'b0) begin
                miscompares++; $display("FAIL bp_hold[%0d] got %b/%h/%b/%b want 1/5a500000/0/0", k, out_valid, result, out_carry, grant_id); end
        end
        in_ready = 1'b1;
        #1;
        vectors++; if (ready_1 !== 1'b1) begin miscompares++; $display("FAIL bp_release_ready got %b want 1", ready_1); end
        @(posedge clk); #1;
        valid_1 = 1'b0;
        vectors++; if (out_valid !== 1'b1 || result !== 32'h0000_000F || out_carry !== 1'b1 || grant_id !== 1'b1) begin
            miscompares++; $display("FAIL bp_load got %b/%h/%b/%b want 1/0000000f/1/1", out_valid, result, out_carry, grant_id); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL bp_drain got %b want 0", out_valid); end
    endtask

    task automatic test_flush_reset();
        do_reset();
        drive(0, '{32'h1111_1111, 8'd0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0});
        @(posedge clk); #1;
        in_ready = 1'b0; flush = 1'b1;
        drive(1, '{32'h2222_2222, 8'd0, 3'd0, 1'b0, 1'b0, 32'h0, 1'b0});
        #1;
        vectors++; if (ready_0 !== 1'b0 || ready_1 !== 1'b0) begin miscompares++; $display("FAIL flush_ready got %b%b want 00", ready_0, ready_1); end
        @(posedge clk); #1;
        flush = 1'b0;
        vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL flush_valid got %b want 0", out_valid); end
        in_ready = 1'b1;
        #1;
        vectors++; if (ready_0 !== 1'b1 || ready_1 !== 1'b0) begin miscompares++; $display("FAIL flush_ptr got %b%b want 10", ready_0, ready_1); end
        @(posedge clk); #1;
        valid_0 = 1'b0;
        #1;
        vectors++; if (ready_1 !== 1'b1) begin miscompares++; $display("FAIL flush_p1_ready got %b want 1", ready_1); end
        @(posedge clk); #1;
        vectors++; if (grant_id !== 1'b1 || result !== 32'h2222_2222) begin
            miscompares++; $display("FAIL flush_p1_out got %b/%h want 1/22222222", grant_id, result); end
        reset = 1'b1; flush = 1'b1; valid_0 = 1'b1;
        #1;
        vectors++; if (ready_0 !== 1'b0 || ready_1 !== 1'b0) begin miscompares++; $display("FAIL rstflush_ready got %b%b want 00", ready_0, ready_1); end
        @(posedge clk); #1;
        vectors++; if (out_valid !== 1'b0 || result !== 32'h0 || out_carry !== 1'b0 || grant_id !== 1'b0) begin
            miscompares++; $display("FAIL rstflush_out got %b/%h/%b/%b want 0/00000000/0/0", out_valid, result, out_carry, grant_id); end
        reset = 1'b0; flush = 1'b0;
        #1;
        vectors++; if (ready_0 !== 1'b1 || ready_1 !== 1'b0) begin miscompares++; $display("FAIL rst_ptr got %b%b want 10", ready_0, ready_1); end
        valid_0 = 1'b0; valid_1 = 1'b0;
    endtask

    task automatic test_random();
        logic        m_valid, m_carry, m_id, m_ptr;
        logic [31:0] m_result;
        logic        pend0, pend1, g0, g1;
        logic [32:0] exp;
        vec_t        r0, r1;
        do_reset();
        m_valid = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_result = 32'h0;
        pend0 = 0; pend1 = 0;
        r0 = rand_vec(); r1 = rand_vec();
        for (int cyc = 0; cyc < 800; cyc++) begin
            if (!pend0 && $urandom_range(0, 9) < 6) begin r0 = rand_vec(); pend0 = 1'b1; end
            if (!pend1 && $urandom_range(0, 9) < 6) begin r1 = rand_vec(); pend1 = 1'b1; end
            drive(0, r0); valid_0 = pend0;
            drive(1, r1); valid_1 = pend1;
            in_ready = ($urandom_range(0, 9) < 7);
            flush    = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 99) == 0);
            #1;
            g0 = 1'b0; g1 = 1'b0;
            if (!reset && !flush && (!m_valid || in_ready)) begin
                if (pend0 && pend1) begin g0 = !m_ptr; g1 = m_ptr; end
                else begin g0 = pend0; g1 = pend1; end
            end
            vectors++; if (ready_0 !== g0 || ready_1 !== g1) begin
                miscompares++; $display("FAIL rand_ready[%0d] got %b%b want %b%b", cyc, ready_0, ready_1, g0, g1); end
            @(posedge clk);
            if (reset) begin
                m_valid = 0; m_carry = 0; m_id = 0; m_ptr = 0; m_result = 32'h0;
            end else if (flush) begin
                m_valid = 0;
            end else if (g0 || g1) begin
                exp = g1 ? ref_shift(r1) : ref_shift(r0);
                m_valid = 1; m_result = exp[31:0]; m_carry = exp[32]; m_id = g1;
                if (pend0 && pend1) m_ptr = !m_ptr;
            end else if (in_ready) begin
                m_valid = 0;
            end
            if (g0) pend0 = 1'b0;
            if (g1) pend1 = 1'b0;
            #1;
            vectors++; if (out_valid !== m_valid) begin
                miscompares++; $display("FAIL rand_valid[%0d] got %b want %b", cyc, out_valid, m_valid); end
            if (m_valid) begin
                vectors++; if (result !== m_result || out_carry !== m_carry || grant_id !== m_id) begin
                    miscompares++; $display("FAIL rand_out[%0d] got %h/%b/%b want %h/%b/%b", cyc, result, out_carry, grant_id, m_result, m_carry, m_id); end
            end
        end
        reset = 1'b0; flush = 1'b0; valid_0 = 1'b0; valid_1 = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired before end of run");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; flush = 1'b0; in_ready = 1'b1;
        valid_0 = 1'b0; valid_1 = 1'b0;
        source_0 = 32'h0; source_1 = 32'h0; amount_0 = 8'h0; amount_1 = 8'h0;
        type_0 = 3'd0; type_1 = 3'd0; reg_shift_0 = 1'b0; reg_shift_1 = 1'b0;
        carry_in_0 = 1'b0; carry_in_1 = 1'b0;
        test_reset();
        test_contention();
        test_immediate();
        test_reg_large();
        test_backpressure();
        test_flush_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
